// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: the controller state type and
// link-level constants used by the slave and its synchroniser.
package spi_pkg;

    // Controller state: IDLE while deselected, ACTIVE while a frame is open.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Default word length in bits, MSB first on the wire.
    localparam int SPI_DATA_W = 32;

    // Slowest allowed ratio f(ACLK)/f(SCLK); below this the oversampling
    // pipeline cannot resolve every SCLK edge.
    localparam int SPI_MIN_CLK_RATIO = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with one history flop for edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised level
//   rise, fall : single-cycle pulses on synchronised 0->1 / 1->0 transitions
// All flops reset to 0 so that an input already low when reset releases
// produces no fall pulse.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              hist_r;

    // Synchroniser chain plus history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            hist_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~hist_r;
    assign fall = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave running entirely in the ACLK domain.
// Ports:
//   ACLK, ARESETN         : system clock, asynchronous active-low reset
//   SCLK, SS_N, MOSI      : SPI inputs (asynchronous, oversampled)
//   MISO, MISO_OE         : SPI data out and its output enable
//   tx_data/valid/ready   : words to transmit; tx_ready pulses on consume
//   rx_data/valid/ready   : received words; rx_valid held until accepted
//   overrun               : pulse, completed word dropped (rx still held)
//   underrun              : pulse, tx load found no valid word
//   frame_err             : pulse, SS_N released with a partial word
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              SCLK,
    input  logic              SS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun,
    output logic              frame_err
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic sclk_q_s, sclk_rise_s, sclk_fall_s;
    logic ss_q_s, ss_rise_s, ss_fall_s;
    logic mosi_s;
    logic tx_load_s;

    logic [SYNC_STAGES-1:0] mosi_sync_r;
    spi_state_e             state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_W-1:0]      rx_shift_r;
    logic [DATA_W-1:0]      tx_shift_r;
    logic [DATA_W-1:0]      rx_data_r;
    logic                   rx_valid_r;
    logic                   word_done_r;
    logic                   tx_ready_r;
    logic                   underrun_r;
    logic                   overrun_r;
    logic                   frame_err_r;
    logic                   miso_oe_r;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .d     (SCLK),
        .q     (sclk_q_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .d     (SS_N),
        .q     (ss_q_s),
        .rise  (ss_rise_s),
        .fall  (ss_fall_s)
    );

    // MOSI synchroniser; same depth as SCLK so data lines up with the rise pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mosi_sync_r <= '0;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // A tx load happens at frame start and on each falling edge at a word boundary.
    always_comb begin
        tx_load_s = 1'b0;
        if (state_r == IDLE) begin
            tx_load_s = ss_fall_s;
        end else begin
            tx_load_s = !ss_rise_s && !sclk_rise_s && sclk_fall_s && (bit_cnt_r == '0);
        end
    end

    // Frame controller, shift registers and rx/tx handshakes.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r     <= IDLE;
            bit_cnt_r   <= '0;
            rx_shift_r  <= '0;
            tx_shift_r  <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            word_done_r <= 1'b0;
            tx_ready_r  <= 1'b0;
            underrun_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            miso_oe_r   <= 1'b0;
        end else begin
            tx_ready_r  <= 1'b0;
            underrun_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            word_done_r <= 1'b0;

            // A completed word lands one cycle after its last bit was shifted in.
            if (word_done_r) begin
                if (!rx_valid_r || rx_ready) begin
                    rx_data_r  <= rx_shift_r;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (ss_fall_s) begin
                        state_r   <= ACTIVE;
                        bit_cnt_r <= '0;
                        miso_oe_r <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise_s) begin
                        // Releasing select mid-word drops the partial word.
                        state_r    <= IDLE;
                        miso_oe_r  <= 1'b0;
                        bit_cnt_r  <= '0;
                        rx_shift_r <= '0;
                        if (bit_cnt_r != '0) begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                        if (bit_cnt_r == CNT_LAST) begin
                            bit_cnt_r   <= '0;
                            word_done_r <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (sclk_fall_s && (bit_cnt_r != '0)) begin
                        tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (tx_load_s) begin
                if (tx_valid) begin
                    tx_shift_r <= tx_data;
                    tx_ready_r <= 1'b1;
                end else begin
                    tx_shift_r <= '0;
                    underrun_r <= 1'b1;
                end
            end
        end
    end

    assign MISO      = tx_shift_r[DATA_W-1];
    assign MISO_OE   = miso_oe_r;
    assign tx_ready  = tx_ready_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign overrun   = overrun_r;
    assign underrun  = underrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: an SPI mode-0 master model at ACLK/8,
// a tx word source, and event counters compared against expectations
// derived from the frames sent.
module tb_spi_slave;

    localparam int HALF = 4;

    logic        aclk = 1'b0;
    logic        aresetn, sclk, ss_n, mosi;
    logic        miso, miso_oe;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        overrun, underrun, frame_err;

    int checks = 0;
    int errors = 0;

    // Monitor-owned counters and tx source state.
    int          tx_cnt, n_und, n_ovr, n_ferr, n_rxv;
    logic [31:0] got_rx[$];
    // Main-owned tx configuration and model.
    logic [31:0] tx_words [0:63];
    int          tx_lim;
    logic        tx_en;
    int          exp_ptr;

    always #5 aclk = ~aclk;

    spi_slave dut (
        .ACLK      (aclk),
        .ARESETN   (aresetn),
        .SCLK      (sclk),
        .SS_N      (ss_n),
        .MOSI      (mosi),
        .MISO      (miso),
        .MISO_OE   (miso_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    // Monitor: samples once per cycle after the bench's drives have settled.
    initial begin
        tx_cnt = 0; n_und = 0; n_ovr = 0; n_ferr = 0; n_rxv = 0;
        tx_valid = 1'b0;
        tx_data  = 32'h0;
        forever begin
            @(negedge aclk);
            #2;
            if (tx_ready)  tx_cnt++;
            if (underrun)  n_und++;
            if (overrun)   n_ovr++;
            if (frame_err) n_ferr++;
            if (rx_valid)  n_rxv++;
            if (rx_valid && rx_ready) got_rx.push_back(rx_data);
            tx_valid = tx_en && (tx_cnt < tx_lim);
            tx_data  = tx_valid ? tx_words[tx_cnt] : 32'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
        #1;
    endtask

    // Full SPI frame of nbits, MSB first; SS_N rises together with the final SCLK fall.
    task automatic spi_frame(input logic [127:0] data, input int nbits, output logic [127:0] mb);
        mb   = '0;
        ss_n = 1'b0;
        mosi = data[nbits-1];
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            mb[nbits-1-i] = miso;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            if (i == nbits - 1) ss_n = 1'b1;
            else                mosi = data[nbits-2-i];
            tick(HALF);
        end
        tick(4 * HALF);
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            mosi = 1'($urandom);
            tick(HALF);
        end
    endtask

    // One clean frame of nw words with rx_ready high; checks rx, MISO and pulse counts.
    task automatic full_frame(input string tag, input int nw, input logic [95:0] data, input logic [95:0] txw);
        logic [127:0] mb;
        int b_tx, b_rx, b_und, b_ferr, b_ovr, b_rxv;
        logic [31:0] exp_w;
        if (tx_en) begin
            for (int j = 0; j < nw; j++) tx_words[tx_lim + j] = txw[32*(nw-1-j) +: 32];
            tx_lim += nw;
        end
        b_tx = tx_cnt; b_rx = got_rx.size(); b_und = n_und;
        b_ferr = n_ferr; b_ovr = n_ovr; b_rxv = n_rxv;
        spi_frame({32'h0, data}, 32 * nw, mb);
        check({tag, "_rxcnt"}, 64'(got_rx.size() - b_rx), 64'(nw));
        check({tag, "_rxvcyc"}, 64'(n_rxv - b_rxv), 64'(nw));
        for (int j = 0; j < nw; j++) begin
            if (b_rx + j < got_rx.size())
                check($sformatf("%s_rx%0d", tag, j), 64'(got_rx[b_rx+j]), 64'(data[32*(nw-1-j) +: 32]));
            exp_w = tx_en ? txw[32*(nw-1-j) +: 32] : 32'h0;
            check($sformatf("%s_miso%0d", tag, j), 64'(mb[32*(nw-1-j) +: 32]), 64'(exp_w));
        end
        check({tag, "_txrdy"}, 64'(tx_cnt - b_tx), 64'(tx_en ? nw : 0));
        check({tag, "_under"}, 64'(n_und - b_und), 64'(tx_en ? 0 : nw));
        check({tag, "_ferr"}, 64'(n_ferr - b_ferr), 64'(0));
        check({tag, "_ovr"}, 64'(n_ovr - b_ovr), 64'(0));
        check({tag, "_oe"}, 64'(miso_oe), 64'(0));
        if (tx_en) exp_ptr += nw;
    endtask

    initial begin
        logic [127:0] mb;
        int b_ovr, b_rx, b_ferr, b_rxv, b_tx, nw;
        logic [31:0] w;

        aresetn = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        rx_ready = 1'b1; tx_en = 1'b1; tx_lim = 0; exp_ptr = 0;
        for (int i = 0; i < 64; i++) tx_words[i] = 32'h0;
        tick(3);
        check("reset_outputs", 64'({miso, miso_oe, tx_ready, rx_valid, overrun, underrun, frame_err, rx_data}), 64'(0));
        aresetn = 1'b1;
        tick(5);
        check("idle_outputs", 64'({miso_oe, tx_ready, rx_valid, overrun, underrun, frame_err, rx_data}), 64'(0));

        // Single word.
        full_frame("single", 1, 96'hDEADBEEF, 96'hA5A5A5A5);

        // Back-to-back words in one frame.
        full_frame("b2b", 3, {32'h1, 32'h2, 32'h3}, {32'h10, 32'h20, 32'h30});

        // Overrun: second word dropped while the first is held.
        rx_ready = 1'b0;
        tx_words[tx_lim] = $urandom; tx_words[tx_lim+1] = $urandom; tx_lim += 2;
        b_ovr = n_ovr; b_rx = got_rx.size(); b_tx = tx_cnt;
        spi_frame({64'h0, 32'h11111111, 32'h22222222}, 64, mb);
        exp_ptr += 2;
        check("ovr_pulses", 64'(n_ovr - b_ovr), 64'(1));
        check("ovr_rxvalid", 64'(rx_valid), 64'(1));
        check("ovr_rxdata", 64'(rx_data), 64'(32'h11111111));
        check("ovr_txrdy", 64'(tx_cnt - b_tx), 64'(2));
        rx_ready = 1'b1;
        tick(3);
        check("ovr_drain_cnt", 64'(got_rx.size() - b_rx), 64'(1));
        if (got_rx.size() > b_rx) check("ovr_drain_data", 64'(got_rx[b_rx]), 64'(32'h11111111));
        check("ovr_drain_valid", 64'(rx_valid), 64'(0));

        // Underrun: nothing to send.
        tx_en = 1'b0;
        full_frame("under", 1, {64'h0, 32'($urandom)}, 96'h0);
        tx_en = 1'b1;

        // Abort after 17 bits, then a clean frame.
        tx_words[tx_lim] = $urandom; tx_lim += 1;
        b_ferr = n_ferr; b_rx = got_rx.size(); b_rxv = n_rxv;
        spi_frame(128'($urandom), 17, mb);
        exp_ptr += 1;
        check("abort_ferr", 64'(n_ferr - b_ferr), 64'(1));
        check("abort_norx", 64'(got_rx.size() - b_rx), 64'(0));
        check("abort_norxv", 64'(n_rxv - b_rxv), 64'(0));
        full_frame("after_abort", 1, 96'hCAFEF00D, {64'h0, 32'($urandom)});

        // Reset in the middle of a frame.
        tx_words[tx_lim] = $urandom; tx_lim += 1;
        b_rx = got_rx.size(); b_rxv = n_rxv;
        ss_n = 1'b0; mosi = 1'($urandom);
        tick(HALF);
        clocks(10);
        check("rst_pre_oe", 64'(miso_oe), 64'(1));
        aresetn = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({miso, miso_oe, tx_ready, rx_valid, overrun, underrun, frame_err, rx_data}), 64'(0));
        exp_ptr += 1;
        tick(2);
        aresetn = 1'b1;
        tick(2);
        clocks(22);
        check("rst_norx", 64'(got_rx.size() - b_rx), 64'(0));
        check("rst_norxv", 64'(n_rxv - b_rxv), 64'(0));
        ss_n = 1'b1;
        tick(8);
        w = $urandom;
        full_frame("after_rst", 1, {64'h0, w}, {64'h0, 32'($urandom)});

        // Randomised clean frames.
        for (int k = 0; k < 4; k++) begin
            nw = int'($urandom_range(1, 3));
            full_frame($sformatf("rand%0d", k), nw,
                       {32'($urandom), 32'($urandom), 32'($urandom)},
                       {32'($urandom), 32'($urandom), 32'($urandom)});
        end

        check("tx_consumed_total", 64'(tx_cnt), 64'(exp_ptr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
